// File: rtl/cache_pkg.sv
// cache_pkg: shared command, MESI, bus-op, snoop and FSM encodings for the LLC directory.
//   cmd_e    : trace command codes 0-6, 8 (clear) and 9 (print)
//   mesi_e   : line coherence state, I=0
//   bus_op_e : bus transaction issued by this cache
//   snoop_e  : snoop result, both received (snoop_in) and returned (rsp_snoop_res)
//   fsm_e    : directory controller states
package cache_pkg;
    typedef enum logic [3:0] {
        CMD_RD = 4'd0, CMD_WR = 4'd1, CMD_IFETCH = 4'd2, CMD_SNP_INV = 4'd3, CMD_SNP_RD = 4'd4,
        CMD_SNP_WR = 4'd5, CMD_SNP_RWIM = 4'd6, CMD_CLEAR = 4'd8, CMD_PRINT = 4'd9
    } cmd_e;
    typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_e;
    typedef enum logic [2:0] {BUS_NONE, BUS_READ, BUS_WRITE, BUS_RWIM, BUS_INV} bus_op_e;
    typedef enum logic [1:0] {SNP_NOHIT, SNP_HIT, SNP_HITM} snoop_e;
    typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_UPDATE, ST_CLEAR} fsm_e;
endpackage

// File: rtl/cache_plru_tree.sv
// cache_plru_tree: combinational tree-PLRU victim walk and access update for one set.
//   plru       in  WAYS-1 tree bits, heap order (node n has children 2n+1 / 2n+2)
//   access_way in  way being touched
//   victim_way out way the tree currently points at
//   plru_next  out tree bits after touching access_way
module cache_plru_tree #(
    parameter int WAYS = 8,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  plru,
    input  logic [WAY_W-1:0] access_way,
    output logic [WAY_W-1:0] victim_way,
    output logic [WAYS-2:0]  plru_next
);
    logic [WAY_W-1:0] w_vn;
    logic [WAY_W-1:0] w_an;
    always_comb begin
        victim_way = '0;
        plru_next  = plru;
        w_vn       = '0;
        w_an       = '0;
        // Walk root to leaf; way bits come out MSB first. A 0 bit means go left.
        for (int l = 0; l < WAY_W; l++) begin
            victim_way[WAY_W-1-l] = plru[w_vn];
            w_vn = WAY_W'({w_vn, 1'b1} + (WAY_W+1)'(plru[w_vn]));
            // Point each node on the accessed path at the opposite subtree.
            plru_next[w_an] = ~access_way[WAY_W-1-l];
            w_an = WAY_W'({w_an, 1'b1} + (WAY_W+1)'(access_way[WAY_W-1-l]));
        end
    end
endmodule

// File: rtl/cache_mesi_dir.sv
// cache_mesi_dir: N-way set-associative tag/MESI/PLRU directory; one trace command per request.
//   clk, rstb (async, active-low)
//   req_valid/req_ready/req_cmd/req_addr/snoop_in : request, accepted in IDLE only
//   rsp_valid plus rsp_hit/way/state/bus_op/snoop_res/evict/evict_tag : one-cycle response
module cache_mesi_dir
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int NUM_SETS   = 16384,
    parameter int WAYS       = 8,
    parameter int LINE_BYTES = 64,
    localparam int OFF_W = $clog2(LINE_BYTES),
    localparam int IDX_W = $clog2(NUM_SETS),
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        snoop_in,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [WAY_W-1:0]  rsp_way,
    output logic [1:0]        rsp_state,
    output logic [2:0]        rsp_bus_op,
    output logic [1:0]        rsp_snoop_res,
    output logic              rsp_evict,
    output logic [TAG_W-1:0]  rsp_evict_tag
);
    fsm_e                     r_state, w_state_nxt;
    logic [ADDR_W-OFF_W-1:0]  r_line;
    logic [3:0]               r_cmd;
    logic [1:0]               r_snoop;
    logic [IDX_W-1:0]         r_clr_idx;
    logic [1:0]               r_mesi [NUM_SETS][WAYS];
    logic [TAG_W-1:0]         r_tag  [NUM_SETS][WAYS];
    logic [WAYS-2:0]          r_plru [NUM_SETS];
    logic                     r_hit, r_evict;
    logic [WAY_W-1:0]         r_way;
    logic [1:0]               r_st, r_snp;
    logic [2:0]               r_bus;
    logic [TAG_W-1:0]         r_etag;
    logic [IDX_W-1:0]         w_idx;
    logic [TAG_W-1:0]         w_tag;
    logic [WAYS-1:0]          w_match, w_inv;
    logic [WAY_W-1:0]         w_hit_way, w_inv_way, w_victim, w_fill_way, w_way;
    logic [WAYS-2:0]          w_plru_next;
    logic                     w_hit, w_own, w_snoop, w_evict, w_fill, w_mesi_we, w_clr_last, w_accept, w_unused;
    logic [1:0]               w_cur, w_new, w_snp;
    logic [2:0]               w_bus;
    assign w_idx      = r_line[IDX_W-1:0];
    assign w_tag      = r_line[ADDR_W-OFF_W-1:IDX_W];
    assign w_unused   = ^req_addr[OFF_W-1:0];
    assign w_accept   = req_valid & req_ready;
    assign w_clr_last = r_clr_idx == IDX_W'(NUM_SETS - 1);
    assign w_own      = r_cmd inside {CMD_RD, CMD_WR, CMD_IFETCH};
    assign w_snoop    = r_cmd inside {CMD_SNP_INV, CMD_SNP_RD, CMD_SNP_WR, CMD_SNP_RWIM};
    for (genvar g = 0; g < WAYS; g++) begin : g_cmp
        assign w_inv[g]   = r_mesi[w_idx][g] == MESI_I;
        assign w_match[g] = !w_inv[g] && r_tag[w_idx][g] == w_tag;
    end
    // Lowest-index matching way and lowest-index invalid way.
    always_comb begin
        w_hit_way = '0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_match[w]) w_hit_way = WAY_W'(w);
            if (w_inv[w]) w_inv_way = WAY_W'(w);
        end
    end
    assign w_hit      = |w_match;
    assign w_cur      = w_hit ? r_mesi[w_idx][w_hit_way] : MESI_I;
    assign w_fill_way = |w_inv ? w_inv_way : w_victim;
    assign w_way      = w_hit ? w_hit_way : w_fill_way;
    assign w_evict    = w_own && !w_hit && r_mesi[w_idx][w_fill_way] == MESI_M;
    cache_plru_tree #(.WAYS(WAYS)) u_plru (
        .plru       (r_plru[w_idx]),
        .access_way (w_way),
        .victim_way (w_victim),
        .plru_next  (w_plru_next)
    );
    always_comb begin
        w_new     = w_cur;
        w_bus     = BUS_NONE;
        w_snp     = SNP_NOHIT;
        w_mesi_we = 1'b0;
        w_fill    = 1'b0;
        if (w_own) begin
            w_mesi_we = 1'b1;
            w_fill    = !w_hit;
            w_new = (r_cmd == CMD_WR) ? MESI_M : w_hit ? w_cur : (r_snoop == SNP_NOHIT) ? MESI_E : MESI_S;
            w_bus = (r_cmd == CMD_WR) ? (!w_hit ? BUS_RWIM : (w_cur == MESI_S) ? BUS_INV : BUS_NONE)
                                      : (w_hit ? BUS_NONE : BUS_READ);
        end else if (w_snoop && w_hit) begin
            w_mesi_we = 1'b1;
            case (r_cmd)
                CMD_SNP_INV:  w_new = (w_cur == MESI_S) ? MESI_I : w_cur;
                CMD_SNP_RD: begin
                    w_new = MESI_S;
                    w_snp = (w_cur == MESI_M) ? SNP_HITM : SNP_HIT;
                end
                CMD_SNP_RWIM: begin
                    w_new = MESI_I;
                    w_snp = (w_cur == MESI_M) ? SNP_HITM : SNP_HIT;
                end
                default: ;
            endcase
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = (req_cmd == CMD_CLEAR) ? ST_CLEAR : ST_LOOKUP;
            end
            ST_LOOKUP: w_state_nxt = ST_UPDATE;
            ST_UPDATE: begin
                rsp_valid   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                rsp_valid = w_clr_last;
                if (w_clr_last) w_state_nxt = ST_IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end
    // Arrays are written at the end of LOOKUP, so UPDATE already reflects them for the next request.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_line    <= '0;
            r_cmd     <= '0;
            r_snoop   <= '0;
            r_clr_idx <= '0;
            {r_hit, r_evict, r_way, r_st, r_snp, r_bus, r_etag} <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_plru[s[IDX_W-1:0]] <= '0;
                for (int w = 0; w < WAYS; w++) r_mesi[s[IDX_W-1:0]][w[WAY_W-1:0]] <= MESI_I;
            end
        end else begin
            if (w_accept) begin
                r_line    <= req_addr[ADDR_W-1:OFF_W];
                r_cmd     <= req_cmd;
                r_snoop   <= snoop_in;
                r_clr_idx <= '0;
                {r_hit, r_evict, r_way, r_st, r_snp, r_bus, r_etag} <= '0;
            end
            if (r_state == ST_CLEAR) begin
                r_clr_idx         <= r_clr_idx + 1'b1;
                r_plru[r_clr_idx] <= '0;
                for (int w = 0; w < WAYS; w++) r_mesi[r_clr_idx][w[WAY_W-1:0]] <= MESI_I;
            end
            if (r_state == ST_LOOKUP) begin
                r_hit   <= (w_own | w_snoop) & w_hit;
                r_way   <= (w_own | (w_snoop & w_hit)) ? w_way : '0;
                r_st    <= (w_own | w_snoop) ? w_new : MESI_I;
                r_bus   <= w_bus;
                r_snp   <= w_snp;
                r_evict <= w_evict;
                r_etag  <= w_evict ? r_tag[w_idx][w_fill_way] : '0;
                if (w_mesi_we) r_mesi[w_idx][w_way] <= w_new;
                if (w_own) r_plru[w_idx] <= w_plru_next;
            end
        end
    end
    // Tags carry no meaning while the line is I, so they need no reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_LOOKUP && w_fill) r_tag[w_idx][w_way] <= w_tag;
    end
    assign rsp_hit       = r_hit;
    assign rsp_way       = r_way;
    assign rsp_state     = r_st;
    assign rsp_bus_op    = r_bus;
    assign rsp_snoop_res = r_snp;
    assign rsp_evict     = r_evict;
    assign rsp_evict_tag = r_etag;
    a_one_match: assert property (@(posedge clk) disable iff (!rstb) (r_state == ST_LOOKUP) |-> $onehot0(w_match));
endmodule
